// File: rtl/trng_sequencer.sv
// Sequencer for an array of quench/excite entropy cells: drives T/I1/I2, samples the cells
// through a 2-flop synchronizer, folds each sample to one bit and assembles 32-bit words.
module trng_sequencer #(
  parameter int unsigned N_CELLS       = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned REP_LIMIT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               puf_mode,
  output logic [N_CELLS-1:0] cell_t,
  output logic [N_CELLS-1:0] cell_i1,
  output logic [N_CELLS-1:0] cell_i2,
  input  logic [N_CELLS-1:0] cell_out,
  output logic [31:0]        data,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               health_fail
);

  typedef enum logic [2:0] {
    StIdle,
    StQuench,
    StExcite,
    StSample,
    StPack,
    StHold
  } state_e;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] RepLimit   = 4'(REP_LIMIT);

  state_e             state_q, state_d;
  logic [7:0]         phase_q, phase_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [31:0]        data_q, data_d;
  logic               puf_q, puf_d;
  logic [N_CELLS-1:0] sync1_q, sync2_q;
  logic [N_CELLS-1:0] capture_q, capture_d;
  logic [3:0]         stuck_q, stuck_d;
  logic               fail_q, fail_d;
  logic               sample_stuck;

  assign sample_stuck = (capture_q == '0) || (capture_q == '1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    puf_d     = puf_q;
    capture_d = capture_q;
    stuck_d   = stuck_q;
    fail_d    = fail_q;
    cell_t    = '0;
    cell_i1   = '0;
    cell_i2   = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StQuench;
          puf_d     = puf_mode;
          data_d    = '0;
          bit_cnt_d = '0;
          phase_d   = '0;
        end
      end
      StQuench: begin
        if (phase_q == 8'd1) begin
          state_d = StExcite;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StExcite: begin
        cell_t  = '1;
        cell_i1 = '1;
        cell_i2 = {N_CELLS{puf_q}};
        if (phase_q == SettleLast) begin
          state_d = StSample;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StSample: begin
        // Excitation is held while the synchronizer settles on the cell outputs.
        cell_t  = '1;
        cell_i1 = '1;
        cell_i2 = {N_CELLS{puf_q}};
        if (phase_q == 8'd1) begin
          capture_d = sync2_q;
          state_d   = StPack;
          phase_d   = '0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StPack: begin
        data_d    = {data_q[30:0], ^capture_q};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (sample_stuck) begin
          stuck_d = (stuck_q == 4'hF) ? stuck_q : stuck_q + 4'd1;
        end else begin
          stuck_d = '0;
        end
        if (stuck_d >= RepLimit) begin
          fail_d = 1'b1;
        end
        state_d = (bit_cnt_q == 5'd31) ? StHold : StQuench;
      end
      StHold: begin
        if (data_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      puf_q     <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      capture_q <= '0;
      stuck_q   <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      puf_q     <= puf_d;
      sync1_q   <= cell_out;
      sync2_q   <= sync1_q;
      capture_q <= capture_d;
      stuck_q   <= stuck_d;
      fail_q    <= fail_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = (state_q == StHold);
  assign busy        = (state_q != StIdle);
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_sequencer.sv
// Self-checking bench for trng_sequencer: per-bit cell stimulus, expected words queued in a
// scoreboard at drive time and compared when data_valid appears.
module tb_trng_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         puf_mode;
  logic [N-1:0] cell_t;
  logic [N-1:0] cell_i1;
  logic [N-1:0] cell_i2;
  logic [N-1:0] cell_out;
  logic [31:0]  data;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic         health_fail;

  trng_sequencer #(
    .N_CELLS      (N),
    .SETTLE_CYCLES(4),
    .REP_LIMIT    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .puf_mode   (puf_mode),
    .cell_t     (cell_t),
    .cell_i1    (cell_i1),
    .cell_i2    (cell_i2),
    .cell_out   (cell_out),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  pattern[32];
  logic        hf_trace[32];
  int          latency;
  bit          i2_bad;
  bit          timed_out;

  // Runs one word: feeds pattern[k] to the cells at the start of excitation of bit k and
  // queues the expected word built from the parity of each pattern entry.
  task automatic drive_word(input bit puf, input bit toggle_puf);
    logic [31:0] w;
    int          bit_idx;
    logic        prev_t;
    w       = '0;
    bit_idx = 0;
    prev_t  = 1'b0;
    for (int i = 0; i < 32; i++) w = {w[30:0], ^pattern[i]};
    exp_q.push_back(w);
    i2_bad    = 1'b0;
    timed_out = 1'b1;
    latency   = 0;
    @(negedge clk);
    puf_mode = puf;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cell_t[0] && !prev_t && bit_idx < 32) begin
        hf_trace[bit_idx] = health_fail;
        cell_out = pattern[bit_idx];
        bit_idx++;
        if (toggle_puf && bit_idx == 16) puf_mode = ~puf_mode;
      end
      if (cell_t != '0 && cell_i2 !== {N{puf}}) i2_bad = 1'b1;
      prev_t = cell_t[0];
      if (data_valid) begin
        latency   = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept_word();
    @(negedge clk);
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic check_word(input string name);
    logic [31:0] exp;
    n_tests++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL %s_timeout: data_valid never rose within 400 cycles", name);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    if (data !== exp) begin
      n_fail++;
      $display("FAIL %s_data: got %h expected %h", name, data, exp);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b1;
    data_ready = 1'b1;
    puf_mode   = 1'b1;
    cell_out   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b valid=%b expected 0 0", busy, data_valid);
    end
    n_tests++;
    if (data !== 32'h0 || health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h hf=%b expected 0 0", data, health_fail);
    end
    n_tests++;
    if ({cell_t, cell_i1, cell_i2} !== '0) begin
      n_fail++;
      $display("FAIL reset_cells: got %h %h %h expected 0", cell_t, cell_i1, cell_i2);
    end
    rst        = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    puf_mode   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 32; i++) pattern[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
    drive_word(1'b0, 1'b0);
    check_word("alternate");
    n_tests++;
    if (data !== 32'hAAAAAAAA) begin
      n_fail++;
      $display("FAIL alternate_const: got %h expected aaaaaaaa", data);
    end
    n_tests++;
    if (health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL alternate_health: got %b expected 0", health_fail);
    end
    accept_word();
  endtask

  task automatic test_a5();
    for (int i = 0; i < 32; i++) pattern[i] = 8'hA5;
    drive_word(1'b0, 1'b0);
    check_word("a5");
    n_tests++;
    if (latency != 288) begin
      n_fail++;
      $display("FAIL a5_latency: got %0d expected 288", latency);
    end
    n_tests++;
    if (i2_bad) begin
      n_fail++;
      $display("FAIL a5_i2: cell_i2 got nonzero expected 00 during excitation");
    end
    n_tests++;
    if (health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_health: got %b expected 0", health_fail);
    end
    accept_word();
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 32; i++) pattern[i] = 8'hFF;
    drive_word(1'b0, 1'b0);
    check_word("stuck");
    // hf_trace[k] is sampled after k packs have completed.
    for (int k = 1; k < 32; k++) begin
      n_tests++;
      if (hf_trace[k] !== (k >= 3)) begin
        n_fail++;
        $display("FAIL stuck_trace%0d: got %b expected %b", k, hf_trace[k], (k >= 3));
      end
    end
    n_tests++;
    if (health_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_sticky: got %b expected 1", health_fail);
    end
    accept_word();
  endtask

  task automatic test_puf();
    for (int i = 0; i < 32; i++) pattern[i] = 8'($urandom);
    drive_word(1'b1, 1'b1);
    check_word("puf");
    n_tests++;
    if (i2_bad) begin
      n_fail++;
      $display("FAIL puf_i2: cell_i2 got not ff expected ff during excitation");
    end
    accept_word();
  endtask

  task automatic test_hold();
    logic [31:0] held;
    bit          unstable;
    for (int i = 0; i < 32; i++) pattern[i] = 8'($urandom);
    drive_word(1'b0, 1'b0);
    check_word("hold");
    held     = data;
    unstable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      start = (c == 10 || c == 30);
      @(posedge clk);
      @(negedge clk);
      if (data_valid !== 1'b1 || data !== held) unstable = 1'b1;
    end
    start = 1'b0;
    n_tests++;
    if (unstable) begin
      n_fail++;
      $display("FAIL hold_stable: data/valid changed, got %h expected %h", data, held);
    end
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_ready = 1'b0;
    n_tests++;
    if (data_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: valid=%b busy=%b expected 0 0", data_valid, busy);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_queue: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) pattern[i] = 8'($urandom);
    drive_word(1'b0, 1'b0);
    check_word("b2b");
    @(negedge clk);
    start      = 1'b1;
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    data_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b valid=%b expected 0 0", busy, data_valid);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stay: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int   rises;
    logic prev_t;
    bit   found;
    rises    = 0;
    prev_t   = 1'b0;
    found    = 1'b0;
    cell_out = 8'hFF;
    @(negedge clk);
    puf_mode = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cell_t[0] && !prev_t) rises++;
      prev_t = cell_t[0];
      if (rises == 11) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_reach: got %0d excitations expected 11", rises);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (health_fail !== 1'b1 || cell_t !== 8'hFF) begin
      n_fail++;
      $display("FAIL rstmid_pre: hf=%b cell_t=%h expected 1 ff", health_fail, cell_t);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || data !== 32'h0 || health_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_state: busy=%b valid=%b data=%h hf=%b expected 0 0 0 0",
               busy, data_valid, data, health_fail);
    end
    n_tests++;
    if ({cell_t, cell_i1, cell_i2} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_cells: got %h %h %h expected 0", cell_t, cell_i1, cell_i2);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_a5();
    test_stuck();
    test_puf();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
